mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-ported unified memory.
//
// An instruction-fetch port (if_*) and a load/store port (d_*) compete for one
// memory port (mem_*). Requests are level signals held until the matching done
// pulse. On a contest the port not granted last wins. Each transaction either
// completes on mem_ack or is aborted after TIMEOUT ack-free busy cycles, in which
// case done and err pulse together and the read-data registers keep their value.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request and address
//   if_done/if_rdata           fetch completion pulse, fetched word (held)
//   d_req/d_we/d_addr/d_wdata/d_wmask   load/store request
//   d_done/d_rdata             load/store completion pulse, load data (held)
//   err                        abort pulse, coincident with the done pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask   registered memory request
//   mem_ack/mem_rdata          memory response
//   state_o                    FSM state for observation (0 IDLE, 1 BUSY_I, 2 BUSY_D)
//
// Handshake: a requester raises *_req with stable fields and keeps it high until
// its *_done pulse. Towards memory, mem_req and all mem_* fields stay constant
// from the grant edge until the edge on which mem_ack (or the timeout) is seen.

module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_done,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   input  logic [3:0]    d_wmask,
   output logic          d_done,
   output logic [31:0]   d_rdata,
   output logic          err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wmask,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic [1:0]    state_o
);

   // Counter is at least 8 bits wide, wider only if TIMEOUT needs it.
   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   // Value held during the TIMEOUT-th ack-free busy cycle.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   state_e          state_q, state_d;
   logic            last_gnt_q, last_gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic [3:0]      mem_wmask_q, mem_wmask_d;
   logic            if_done_q, if_done_d;
   logic            d_done_q, d_done_d;
   logic            err_q, err_d;
   logic [31:0]     if_rdata_q, if_rdata_d;
   logic [31:0]     d_rdata_q, d_rdata_d;
   logic            pick_d;

   // D wins when it is the only requester, or on a contest when I went last.
   assign pick_d = d_req && (!if_req || (last_gnt_q == GNT_I));

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            // mem_ack is not looked at here.
            if (pick_d) begin
               state_d     = BUSY_D;
               last_gnt_d  = GNT_D;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_wmask_d = d_wmask;
            end else if (if_req) begin
               state_d     = BUSY_I;
               last_gnt_d  = GNT_I;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               mem_wmask_d = '0;
            end
         end

         BUSY_I, BUSY_D: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_I) begin
                  if_rdata_d = mem_rdata;
                  if_done_d  = 1'b1;
               end else begin
                  // Stores leave the load-data register alone.
                  if (!mem_we_q) d_rdata_d = mem_rdata;
                  d_done_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               if (state_q == BUSY_I) if_done_d = 1'b1;
               else                   d_done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_gnt_q  <= GNT_I;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign err       = err_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A transaction-level reference model decides, at each
// grant, which port wins and computes from the chosen ack delay the cycle range
// in which mem_req must be high, the cycle of the done pulse and whether err
// accompanies it. Expected read data per transaction is queued in exp_q.
module tb_mem_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we, mem_ack;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_wmask;
   logic        if_done, d_done, err, mem_req, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic [1:0]  state_o;

   mem_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_done(d_done), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state_o(state_o)
   );

   // ---------------- clock / reset
   always #5 clk = ~clk;

   // ---------------- bookkeeping
   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- requester state
   bit          pend_i, pend_d;
   logic [31:0] i_addr_v, d_addr_v, d_wdata_v;
   logic        d_we_v;
   logic [3:0]  d_wmask_v;
   int          p_req_i, p_req_d;
   int          force_delay;
   bit          force_rdata_en;
   logic [31:0] force_rdata;
   bit          do_rst, idle_ack_force;

   // ---------------- reference model
   bit          m_busy, m_owner, m_last, m_to, m_seen;
   int          m_end, t_ack;
   logic [31:0] t_addr, t_wdata, t_rdata;
   logic        t_we;
   logic [3:0]  t_wmask;
   logic [31:0] exp_if_rdata, exp_d_rdata;
   logic [31:0] exp_q[$];

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 0; m_to = 0; m_seen = 0;
      m_end = 0; t_ack = 0;
      t_addr = '0; t_wdata = '0; t_rdata = '0; t_we = 1'b0; t_wmask = '0;
      exp_if_rdata = '0; exp_d_rdata = '0;
      exp_q.delete();
   endtask

   task automatic new_i();
      pend_i   = 1;
      i_addr_v = $urandom() & 32'hFFFF_FFFC;
   endtask

   task automatic new_d();
      pend_d    = 1;
      d_addr_v  = ($urandom() & 32'hFFFF_FFFC) | 32'h2;
      d_we_v    = 1'($urandom_range(1));
      d_wdata_v = $urandom();
      d_wmask_v = 4'($urandom_range(15));
   endtask

   task automatic model_grant();
      int  delay;
      bit  win_d;
      win_d   = pend_d && (!pend_i || (m_last == 0));
      m_owner = win_d;
      m_last  = win_d;
      delay   = (force_delay >= 0) ? force_delay : $urandom_range(5);
      t_ack   = cyc + 1 + delay;
      if (delay < TO) begin m_end = t_ack;    m_to = 0; end
      else            begin m_end = cyc + TO; m_to = 1; end
      t_rdata = force_rdata_en ? force_rdata : $urandom();
      if (win_d) begin
         t_addr = d_addr_v; t_we = d_we_v; t_wdata = d_wdata_v; t_wmask = d_wmask_v;
         exp_q.push_back((m_to || d_we_v) ? exp_d_rdata : t_rdata);
      end else begin
         t_addr = i_addr_v; t_we = 1'b0; t_wdata = '0; t_wmask = '0;
         exp_q.push_back(m_to ? exp_if_rdata : t_rdata);
      end
      m_busy = 1;
      m_seen = 1;
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model.
   task automatic step();
      bit comp_i, comp_d;
      @(negedge clk);
      comp_i = 0; comp_d = 0;
      if (m_busy && cyc == m_end + 1) begin
         m_busy = 0;
         if (exp_q.size() == 0) chk("exp_q_empty", 32'd0, 32'd1);
         else if (m_owner) exp_d_rdata  = exp_q.pop_front();
         else              exp_if_rdata = exp_q.pop_front();
         if (m_owner) comp_d = 1; else comp_i = 1;
      end
      chk("mem_req",  32'(mem_req), 32'(m_busy));
      chk("if_done",  32'(if_done), 32'(comp_i));
      chk("d_done",   32'(d_done),  32'(comp_d));
      chk("err",      32'(err),     32'((comp_i || comp_d) && m_to));
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("d_rdata",  d_rdata,  exp_d_rdata);
      chk("state",    32'(state_o), m_busy ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      if (m_busy || !m_seen) begin
         chk("mem_addr",  mem_addr,         t_addr);
         chk("mem_we",    32'(mem_we),      32'(t_we));
         chk("mem_wmask", 32'(mem_wmask),   32'(t_wmask));
         if (m_owner || !m_seen) chk("mem_wdata", mem_wdata, t_wdata);
      end

      // drive requesters
      if (comp_i) pend_i = 0;
      if (comp_d) pend_d = 0;
      if (!pend_i && $urandom_range(99) < p_req_i) new_i();
      if (!pend_d && $urandom_range(99) < p_req_d) new_d();
      if_req  = pend_i;   if_addr = i_addr_v;
      d_req   = pend_d;   d_addr  = d_addr_v;
      d_we    = d_we_v;   d_wdata = d_wdata_v; d_wmask = d_wmask_v;
      reset   = do_rst;

      // drive memory
      if (m_busy) begin
         mem_ack   = (!m_to && cyc == t_ack);
         mem_rdata = mem_ack ? t_rdata : $urandom();
      end else begin
         mem_ack   = idle_ack_force ? 1'b1 : 1'($urandom_range(1));
         mem_rdata = $urandom();
      end

      // advance model across the coming edge
      if (do_rst)                            model_reset();
      else if (!m_busy && (pend_i || pend_d)) model_grant();
      cyc++;
   endtask

   task automatic drain(input int bound);
      for (int k = 0; k < bound; k++) begin
         if (!m_busy && !pend_i && !pend_d) break;
         step();
      end
      chk("drain_idle", 32'(m_busy || pend_i || pend_d), 32'd0);
   endtask

   // ---------------- stimulus
   initial begin
      reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
      pend_i = 0; pend_d = 0; i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0;
      d_we_v = 0; d_wmask_v = '0; p_req_i = 0; p_req_d = 0; force_delay = -1;
      force_rdata_en = 0; force_rdata = '0; idle_ack_force = 0;
      model_reset();

      // reset state
      do_rst = 1; repeat (2) step(); do_rst = 0;

      // fetch only, ack two cycles after mem_req
      force_delay = 2; force_rdata_en = 1; force_rdata = 32'h0050_0093;
      pend_i = 1; i_addr_v = 32'h40;
      drain(20);
      chk("fetch_if_rdata", if_rdata, 32'h0050_0093);

      // contest after reset: D first, then alternation while both stay requesting
      force_rdata_en = 0; force_delay = 0;
      do_rst = 1; step(); do_rst = 0;
      new_i(); new_d(); p_req_i = 100; p_req_d = 100;
      repeat (16) step();
      p_req_i = 0; p_req_d = 0;
      drain(30);

      // load, then store that must leave d_rdata alone
      force_rdata_en = 1; force_rdata = 32'h1234_5678; force_delay = 1;
      pend_d = 1; d_we_v = 0; d_addr_v = 32'h200; d_wmask_v = 4'hF;
      drain(20);
      force_rdata = 32'hA5A5_A5A5;
      pend_d = 1; d_we_v = 1; d_addr_v = 32'h100; d_wdata_v = 32'hDEAD_BEEF; d_wmask_v = 4'b0011;
      drain(20);
      chk("store_keeps_d_rdata", d_rdata, 32'h1234_5678);

      // timeout with mem_ack never given
      force_delay = 50;
      pend_d = 1; d_we_v = 0; d_addr_v = 32'h300;
      drain(20);
      chk("timeout_keeps_d_rdata", d_rdata, 32'h1234_5678);

      // reset in the middle of a fetch, followed by late acks
      force_delay = 10;
      pend_i = 1; i_addr_v = 32'h80;
      step(); step();
      pend_i = 0;
      do_rst = 1; step(); do_rst = 0;
      idle_ack_force = 1; repeat (3) step(); idle_ack_force = 0;
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_req",  32'(mem_req), 32'd0);

      // back-to-back loads/stores with immediate ack
      force_rdata_en = 0; force_delay = 0;
      new_d(); p_req_d = 100;
      repeat (12) step();
      p_req_d = 0;
      drain(20);

      // randomized traffic with random delays, timeouts and occasional resets
      force_delay = -1; p_req_i = 30; p_req_d = 30;
      for (int n = 0; n < 2000; n++) begin
         do_rst = ($urandom_range(199) == 0);
         step();
      end
      do_rst = 0; p_req_i = 0; p_req_d = 0;
      drain(60);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
